// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin arbiter sharing one Wishbone memory between instruction and data ports,
// with per-transfer timeout, abort handling and a contention counter.
module wb_mem_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      iwb_adr_i,
   input  logic             iwb_cyc_i,
   input  logic             iwb_stb_i,
   output logic [31:0]      iwb_dat_o,
   output logic             iwb_ack_o,
   output logic             iwb_err_o,
   input  logic [31:0]      dwb_adr_i,
   input  logic [31:0]      dwb_dat_i,
   input  logic             dwb_we_i,
   input  logic [3:0]       dwb_sel_i,
   input  logic             dwb_cyc_i,
   input  logic             dwb_stb_i,
   output logic [31:0]      dwb_dat_o,
   output logic             dwb_ack_o,
   output logic             dwb_err_o,
   output logic [31:0]      mem_adr_o,
   output logic [31:0]      mem_dat_o,
   output logic             mem_we_o,
   output logic [3:0]       mem_sel_o,
   output logic             mem_cyc_o,
   output logic             mem_stb_o,
   input  logic [31:0]      mem_dat_i,
   input  logic             mem_ack_i,
   input  logic             mem_err_i,
   output logic [CNT_W-1:0] contention_cnt
);
   localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
   state_t        state, state_nxt;
   logic          last_d, last_d_nxt;
   logic [WW-1:0] wait_cnt;
   logic          i_req, d_req, gnt_i, gnt_d, own_cyc, tout, active, ack, err;
   assign i_req   = iwb_cyc_i & iwb_stb_i;
   assign d_req   = dwb_cyc_i & dwb_stb_i;
   assign gnt_i   = state == GNT_I;
   assign gnt_d   = state == GNT_D;
   assign own_cyc = gnt_i ? iwb_cyc_i : (gnt_d & dwb_cyc_i);
   // A real memory response in the last allowed cycle still wins over the timeout.
   assign tout    = (gnt_i | gnt_d) && wait_cnt == WW'(TIMEOUT) && !mem_ack_i && !mem_err_i;
   assign active  = own_cyc & ~tout;
   assign err     = own_cyc & (tout | mem_err_i);
   assign ack     = active & mem_ack_i & ~mem_err_i;
   assign mem_cyc_o = active;
   assign mem_stb_o = active;
   assign mem_adr_o = gnt_d ? dwb_adr_i : (gnt_i ? iwb_adr_i : '0);
   assign mem_dat_o = gnt_d ? dwb_dat_i : '0;
   assign mem_we_o  = gnt_d & dwb_we_i;
   assign mem_sel_o = gnt_d ? dwb_sel_i : (gnt_i ? 4'hF : 4'h0);
   assign iwb_dat_o = gnt_i ? mem_dat_i : '0;
   assign dwb_dat_o = gnt_d ? mem_dat_i : '0;
   assign iwb_ack_o = gnt_i & ack;
   assign dwb_ack_o = gnt_d & ack;
   assign iwb_err_o = gnt_i & err;
   assign dwb_err_o = gnt_d & err;
   always_comb begin
      state_nxt  = state;
      last_d_nxt = last_d;
      if (state == IDLE) begin
         if (i_req & d_req) state_nxt = last_d ? GNT_I : GNT_D;
         else if (d_req)    state_nxt = GNT_D;
         else if (i_req)    state_nxt = GNT_I;
      end else if (!own_cyc) begin
         state_nxt = IDLE;
      end else if (ack | err) begin
         state_nxt  = IDLE;
         last_d_nxt = gnt_d;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         last_d         <= 1'b0;
         wait_cnt       <= '0;
         contention_cnt <= '0;
      end else begin
         state          <= state_nxt;
         last_d         <= last_d_nxt;
         wait_cnt       <= (state == IDLE || state_nxt == IDLE) ? '0 : wait_cnt + 1'b1;
         contention_cnt <= contention_cnt + CNT_W'(state == IDLE && i_req && d_req);
      end
   end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed checks of grant order, pass-through, timeout, abort and reset.
module tb_wb_mem_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] iwb_adr_i = '0, iwb_dat_o;
   logic        iwb_cyc_i = 1'b0, iwb_stb_i = 1'b0, iwb_ack_o, iwb_err_o;
   logic [31:0] dwb_adr_i = '0, dwb_dat_i = '0, dwb_dat_o;
   logic        dwb_we_i = 1'b0, dwb_cyc_i = 1'b0, dwb_stb_i = 1'b0, dwb_ack_o, dwb_err_o;
   logic [3:0]  dwb_sel_i = '0, mem_sel_o;
   logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i = '0;
   logic        mem_we_o, mem_cyc_o, mem_stb_o, mem_ack_i = 1'b0, mem_err_i = 1'b0;
   logic [31:0] contention_cnt;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   wb_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
      .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
      .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i),
      .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
      .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
      .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
      .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o),
      .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
      .contention_cnt(contention_cnt)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic ireq(input logic on, input logic [31:0] adr);
      iwb_cyc_i = on; iwb_stb_i = on; iwb_adr_i = adr;
   endtask
   task automatic dreq(input logic on, input logic [31:0] adr, input logic [31:0] dat, input logic we);
      dwb_cyc_i = on; dwb_stb_i = on; dwb_adr_i = adr; dwb_dat_i = dat; dwb_we_i = we; dwb_sel_i = 4'hF;
   endtask
   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      tick();
   endtask
   initial begin
      int errs;
      int cycs;
      logic [31:0] exp_adr;
      // reset state
      #2;
      chk("rst_mem_cyc", {31'b0, mem_cyc_o}, 0);
      chk("rst_cnt", contention_cnt, 0);
      chk("rst_acks", {28'b0, iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}, 0);
      #6 rst_n = 1'b1;
      tick();
      // instruction-only read
      ireq(1, 32'h100);
      #1 chk("i_idle_cyc", {31'b0, mem_cyc_o}, 0);
      tick();
      chk("i_gnt_cyc", {31'b0, mem_cyc_o}, 1);
      chk("i_gnt_adr", mem_adr_o, 32'h100);
      chk("i_gnt_sel_we", {27'b0, mem_sel_o, mem_we_o}, 32'h1E);
      chk("i_wait_ack", {31'b0, iwb_ack_o}, 0);
      tick();
      mem_ack_i = 1; mem_dat_i = 32'h13;
      #1;
      chk("i_ack", {31'b0, iwb_ack_o}, 1);
      chk("i_dat", iwb_dat_o, 32'h13);
      chk("i_d_ack", {31'b0, dwb_ack_o}, 0);
      chk("i_d_dat", dwb_dat_o, 0);
      tick();
      mem_ack_i = 0; ireq(0, 0);
      #1 chk("i_done_ack", {31'b0, iwb_ack_o}, 0);
      // simultaneous requests after reset: data first
      dreq(1, 32'h1000, 32'h1, 1); ireq(1, 32'h200);
      tick();
      chk("c_cnt1", contention_cnt, 1);
      chk("c_d_adr", mem_adr_o, 32'h1000);
      chk("c_d_we_sel", {27'b0, mem_sel_o, mem_we_o}, 32'h1F);
      chk("c_d_dat", mem_dat_o, 32'h1);
      mem_ack_i = 1; mem_dat_i = 32'hAAAA_5555;
      #1;
      chk("c_d_ack", {30'b0, dwb_ack_o, iwb_ack_o}, 2);
      chk("c_i_dat0", iwb_dat_o, 0);
      tick();
      mem_ack_i = 0; dreq(0, 0, 0, 0);
      #1 chk("c_idle_gap", {31'b0, mem_cyc_o}, 0);
      tick();
      chk("c_i_adr", mem_adr_o, 32'h200);
      chk("c_i_we", {31'b0, mem_we_o}, 0);
      mem_ack_i = 1;
      #1 chk("c_i_ack", {30'b0, dwb_ack_o, iwb_ack_o}, 1);
      tick();
      mem_ack_i = 0; ireq(0, 0);
      #1 chk("c_cnt_hold", contention_cnt, 1);
      // four back-to-back contended transfers alternate D,I,D,I
      reset_pulse();
      dreq(1, 32'h2000, 32'h7, 1); ireq(1, 32'h300);
      for (int k = 0; k < 4; k++) begin
         tick();
         exp_adr = (k % 2 == 0) ? 32'h2000 : 32'h300;
         chk($sformatf("rr_adr%0d", k), mem_adr_o, exp_adr);
         mem_ack_i = 1;
         tick();
         mem_ack_i = 0;
         if (k == 3) begin
            dreq(0, 0, 0, 0); ireq(0, 0);
         end
         #1 chk($sformatf("rr_gap%0d", k), {31'b0, mem_cyc_o}, 0);
      end
      tick();
      chk("rr_cnt4", contention_cnt, 4);
      // data transfer that memory never answers
      dreq(1, 32'h3000, 32'h9, 0);
      tick();
      errs = 0; cycs = 0;
      for (int k = 0; k < 255; k++) begin
         #1;
         errs += int'(dwb_err_o);
         cycs += int'(mem_cyc_o);
         tick();
      end
      chk("to_early_err", errs, 0);
      chk("to_cyc_held", cycs, 255);
      #1;
      chk("to_err", {31'b0, dwb_err_o}, 1);
      chk("to_cyc_drop", {31'b0, mem_cyc_o}, 0);
      chk("to_ack", {31'b0, dwb_ack_o}, 0);
      tick();
      dreq(0, 0, 0, 0);
      #1 chk("to_idle", {30'b0, dwb_err_o, mem_cyc_o}, 0);
      tick();
      // ack and err together: err wins
      ireq(1, 32'h400);
      tick();
      mem_ack_i = 1; mem_err_i = 1;
      #1 chk("ae_i", {30'b0, iwb_err_o, iwb_ack_o}, 2);
      tick();
      mem_ack_i = 0; mem_err_i = 0; ireq(0, 0);
      tick();
      // abort leaves last_grant on instruction, so data wins the next conflict
      dreq(1, 32'h5000, 32'h0, 0);
      tick();
      dwb_cyc_i = 0; mem_ack_i = 1;
      #1 chk("ab_drop", {29'b0, mem_cyc_o, mem_stb_o, dwb_ack_o}, 0);
      tick();
      mem_ack_i = 0;
      dreq(1, 32'h5000, 32'h0, 0); ireq(1, 32'h500);
      tick();
      chk("ab_rr_adr", mem_adr_o, 32'h5000);
      chk("ab_cnt5", contention_cnt, 5);
      mem_ack_i = 1;
      tick();
      mem_ack_i = 0; dreq(0, 0, 0, 0); ireq(0, 0);
      tick();
      // asynchronous reset in the middle of a data grant
      dreq(1, 32'h6000, 32'h6, 1);
      tick();
      chk("ar_gnt", {31'b0, mem_cyc_o}, 1);
      #2 rst_n = 0; mem_ack_i = 1; mem_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("ar_ctl", {28'b0, mem_cyc_o, mem_stb_o, mem_we_o, dwb_ack_o}, 0);
      chk("ar_adr", mem_adr_o, 0);
      chk("ar_dat", dwb_dat_o, 0);
      chk("ar_cnt", contention_cnt, 0);
      dreq(0, 0, 0, 0);
      #2 rst_n = 1;
      cycs = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         cycs += int'(dwb_ack_o) + int'(mem_cyc_o);
      end
      chk("ar_quiet", cycs, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles a granted transfer may wait for mem_ack_i before it is aborted with an error.
REQ-002 SHALL have parameter CNT_W, default 32: width of the contention counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 iwb_adr_i  input  32  instruction-port byte address.
REQ-006 iwb_cyc_i, iwb_stb_i  input  1 each  instruction-port request (read-only).
REQ-007 iwb_dat_o  output  32  instruction read data.
REQ-008 iwb_ack_o, iwb_err_o  output  1 each  instruction-port completion / error.
REQ-009 dwb_adr_i, dwb_dat_i  input  32 each  data-port address / write data.
REQ-010 dwb_we_i  input  1  data-port write enable.
REQ-011 dwb_sel_i  input  4  data-port byte lanes.
REQ-012 dwb_cyc_i, dwb_stb_i  input  1 each  data-port request.
REQ-013 dwb_dat_o  output  32  data-port read data.
REQ-014 dwb_ack_o, dwb_err_o  output  1 each  data-port completion / error.
REQ-015 mem_adr_o, mem_dat_o  output  32 each  shared-memory address / write data.
REQ-016 mem_we_o  output  1; mem_sel_o  output  4; mem_cyc_o, mem_stb_o  output  1 each  shared-memory master controls.
REQ-017 mem_dat_i  input  32; mem_ack_i, mem_err_i  input  1 each  shared-memory response.
REQ-018 contention_cnt  output  CNT_W  count of cycles in which both ports requested in IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-020 A port request is defined as cyc&stb.
REQ-021 In IDLE with exactly one request: go to the state granting that port on the next edge.
REQ-022 In IDLE with both requests: grant the port not granted last (round-robin via a last_grant flop; reset value = instruction, so data wins the first conflict), and increment contention_cnt (wraps modulo 2^CNT_W).
REQ-023 In IDLE with no request: stay; mem_cyc_o = mem_stb_o = 0.
REQ-024 In GNT_x: mem_* SHALL mirror the granted port combinationally (instruction grant: mem_we_o=0, mem_sel_o=4'hF, mem_dat_o=0); mem_cyc_o = mem_stb_o = 1.
REQ-025 In GNT_x: mem_ack_i SHALL pass combinationally to x_ack_o, with mem_dat_i on x_dat_o, in the same cycle; the FSM returns to IDLE on that edge and updates last_grant.
REQ-026 In GNT_x: mem_err_i SHALL pass likewise to x_err_o and return to IDLE; if mem_ack_i and mem_err_i are both high, err wins and ack is suppressed.
REQ-027 The non-granted port SHALL see ack=0, err=0, dat_o=0.
REQ-028 In GNT_x: a wait counter SHALL count cycles; when it reaches TIMEOUT with no ack/err, assert x_err_o for one cycle, drop mem_cyc_o/mem_stb_o in that cycle, and return to IDLE.
REQ-029 In GNT_x: if the granted port deasserts cyc before completion (abort), drop the mem strobes combinationally, return to IDLE without ack, and leave last_grant unchanged.
REQ-030 Minimum latency: request seen in IDLE -> ack in the following cycle if memory acks immediately (2 cycles request-to-ack); back-to-back grants SHALL pass through IDLE for one cycle.
REQ-031 Addresses and data pass unmodified; the arbiter performs no decoding.

Reset
REQ-032 While rst_n=0: state=IDLE, last_grant=instruction, wait counter=0, contention_cnt=0, all ack/err outputs 0, mem_cyc_o=mem_stb_o=mem_we_o=0, all data/address outputs 0.
REQ-033 Reset asserted mid-transfer SHALL abandon it immediately with no ack/err issued; after release, the first action is IDLE arbitration.

Verification
REQ-034 Instruction only, adr=0x100, mem acks 1 cycle after strobe with 0x00000013 -> iwb_ack_o one cycle, iwb_dat_o=0x00000013, dwb_ack_o stays 0.
REQ-035 Both ports request in the same cycle after reset (data write 0x1000, dat=0x1, sel=4'hF) -> data granted first with mem_we_o=1, mem_sel_o=4'hF; instruction granted next; contention_cnt=1.
REQ-036 Both ports request continuously for 4 transfers -> grants alternate D,I,D,I; contention_cnt=4.
REQ-037 Grant data, memory never acks, TIMEOUT=255 -> dwb_err_o pulses exactly once at wait count 255; FSM returns to IDLE.
REQ-038 mem_ack_i and mem_err_i asserted together -> x_err_o=1 and x_ack_o=0.
REQ-039 rst_n pulled low during GNT_D -> all outputs at reset values asynchronously; no ack after release without a new request.
